// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of data_memory.
//   Port 0 = core load/store path, port 1 = DMA/debug master (lockable).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     pK_req_valid/ready       request handshake (ready = granted this cycle)
//     pK_addr/wdata/we/size    request payload (byte addr, size code)
//     p1_lock                  port 1 asks to keep the grant
//     pK_rsp_valid/rdata/err   registered response, one cycle after grant
//     mem_*                    drive to data_memory; mem_rdata is combinational
//   Round-robin arbitration with a bounded port-1 lock, per-port
//   alignment/size/range checks, and no response backpressure.

// Per-port request checker: flags misaligned, illegal-size and
// out-of-range requests. Purely combinational.
module dmem_req_check #(
  parameter int MEM_SIZE   = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic                  we,
  output logic                  err
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LAST_BYTE = AW1'(MEM_SIZE * 4 - 1);

  logic           misalign, illegal, oor;
  logic [2:0]     nbytes;
  logic [AW1-1:0] last;

  always_comb begin
    case (size[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    misalign = (size[1:0] == 2'b01 && addr[0]) ||
               (size == 3'b010 && addr[1:0] != 2'b00);
    // 011, 11x are undefined; unsigned forms (1xx) make no sense for stores
    illegal  = (size == 3'b011) || (size[2] && size[1]) || (we && size[2]);
    // one extra bit so addr near the top of the space cannot wrap
    last     = {1'b0, addr} + AW1'(nbytes) - AW1'(1);
    oor      = last > LAST_BYTE;
    err      = misalign | illegal | oor;
  end
endmodule

module dmem_arbiter #(
  parameter int MEM_SIZE   = 1024,
  parameter int MAX_LOCK   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // port 0
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p0_we,
  input  logic [2:0]            p0_size,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,
  // port 1
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_we,
  input  logic [2:0]            p1_size,
  input  logic                  p1_lock,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,
  // data_memory
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_size,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata;
  logic [NUM_PORTS-1:0][2:0]            size;
  logic [NUM_PORTS-1:0]                 we, valid, err, gnt;

  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};
  assign size  = {p1_size, p0_size};
  assign we    = {p1_we, p0_we};
  assign valid = {p1_req_valid, p0_req_valid};

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_chk
    dmem_req_check #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) u_chk (
      .addr (addr[k]),
      .size (size[k]),
      .we   (we[k]),
      .err  (err[k])
    );
  end

  // arbitration state
  logic       rr;        // 0 favours port 0, 1 favours port 1
  logic       prev_p1;   // port 1 held the grant last cycle
  logic [7:0] lock_cnt;  // lock grants taken while port 0 was waiting
  logic       lock_win;

  assign lock_win = prev_p1 & p1_lock & p1_req_valid & (lock_cnt < LOCK_MAX);

  always_comb begin
    gnt    = '0;
    gnt[1] = ~rst & p1_req_valid & (lock_win | ~p0_req_valid | rr);
    gnt[0] = ~rst & p0_req_valid & ~gnt[1];
  end

  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];

  // memory drive: forced idle when nothing is granted (covers rst too)
  logic sel;
  assign sel = gnt[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (|gnt) begin
      mem_addr  = addr[sel];
      mem_wdata = wdata[sel];
      mem_size  = size[sel];
      mem_read  = ~err[sel] & ~we[sel];
      mem_write = ~err[sel] &  we[sel];
    end
  end

  // registered responses
  logic [NUM_PORTS-1:0]                 rsp_valid, rsp_err;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 1'b0;
      prev_p1   <= 1'b0;
      lock_cnt  <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (gnt[0])      rr <= 1'b1;
      else if (gnt[1]) rr <= 1'b0;
      prev_p1 <= gnt[1];
      // count only when the lock actually starves port 0; saturates at
      // LOCK_MAX because lock_win drops there
      if (gnt[0] || !p1_lock)           lock_cnt <= '0;
      else if (lock_win && p0_req_valid) lock_cnt <= lock_cnt + 8'd1;
      for (int k = 0; k < NUM_PORTS; k++) begin
        rsp_valid[k] <= gnt[k];
        rsp_err[k]   <= gnt[k] & err[k];
        rsp_rdata[k] <= (gnt[k] && mem_read) ? mem_rdata : '0;
      end
    end
  end

  assign p0_rsp_valid = rsp_valid[0];
  assign p0_rsp_err   = rsp_err[0];
  assign p0_rsp_rdata = rsp_rdata[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p1_rsp_err   = rsp_err[1];
  assign p1_rsp_rdata = rsp_rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-addressed
// data_memory model (little-endian, combinational read with sign/zero
// extension, write on the rising edge).
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic [2:0]  p0_size;
  logic        p1_req_valid, p1_req_ready, p1_we, p1_lock, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic [2:0]  p1_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_size;

  dmem_arbiter #(.MEM_SIZE(1024), .MAX_LOCK(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_size(p0_size),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_size(p1_size), .p1_lock(p1_lock),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  // memory model; preload port shares the write block
  logic [7:0]  mem [0:4095];
  logic        ld_en = 1'b0;
  logic [11:0] ld_a = '0;
  logic [31:0] ld_d = '0;
  logic [11:0] ma;
  logic [31:0] mw;
  assign ma = mem_addr[11:0];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_a]         <= ld_d[7:0];
      mem[ld_a + 12'd1] <= ld_d[15:8];
      mem[ld_a + 12'd2] <= ld_d[23:16];
      mem[ld_a + 12'd3] <= ld_d[31:24];
    end else if (mem_write) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_size[1:0] != 2'b00) mem[ma + 12'd1] <= mem_wdata[15:8];
      if (mem_size[1:0] == 2'b10) begin
        mem[ma + 12'd2] <= mem_wdata[23:16];
        mem[ma + 12'd3] <= mem_wdata[31:24];
      end
    end
  end

  // read data is presented regardless of mem_read, so the arbiter's own
  // zeroing of store/error responses is what gets observed
  always_comb begin
    mw = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
    case (mem_size)
      3'b000:  mem_rdata = {{24{mw[7]}}, mw[7:0]};
      3'b001:  mem_rdata = {{16{mw[15]}}, mw[15:0]};
      3'b100:  mem_rdata = {24'd0, mw[7:0]};
      3'b101:  mem_rdata = {16'd0, mw[15:0]};
      default: mem_rdata = mw;
    endcase
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [2:0] sz);
    p0_req_valid = v; p0_addr = a; p0_wdata = d; p0_we = w; p0_size = sz;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [2:0] sz, input logic lk);
    p1_req_valid = v; p1_addr = a; p1_wdata = d; p1_we = w; p1_size = sz; p1_lock = lk;
  endtask

  logic [11:0] pre_a [5] = '{12'h004, 12'h010, 12'h020, 12'h040, 12'h008};
  logic [31:0] pre_d [5] = '{32'hCAFEF00D, 32'h11223344, 32'h55667788, 32'h0, 32'h0};
  // rejected requests: addr, size, we
  logic [31:0] err_a  [6] = '{32'h6, 32'h3, 32'h8, 32'hFFE, 32'h1000, 32'h4};
  logic [2:0]  err_sz [6] = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b010, 3'b011};
  logic        err_we [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    // reset with both ports requesting; memory preloaded meanwhile
    set0(1'b1, 32'h10, 32'hAAAA5555, 1'b1, 3'b010);
    set1(1'b1, 32'h20, 32'h0, 1'b0, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ld_en = 1'b1; ld_a = pre_a[i]; ld_d = pre_d[i];
      #1;
      chk("rst_rdy", {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
      chk("rst_mem", {30'd0, mem_read, mem_write}, 32'd0);
      step();
      chk("rst_rsp", {28'd0, p0_rsp_valid, p0_rsp_err, p1_rsp_valid, p1_rsp_err}, 32'd0);
      chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
    end
    ld_en = 1'b0;

    // round robin: p0 first after reset, then alternating
    rst = 1'b0;
    set0(1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy", {30'd0, p1_req_ready, p0_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_maddr", mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      step();
      chk("rr_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdata", (i % 2 == 0) ? p0_rsp_rdata : p1_rsp_rdata,
          (i % 2 == 0) ? 32'h11223344 : 32'h55667788);
    end

    // store then loads through memory
    set1(1'b0, 32'h0, 32'h0, 1'b0, 3'b010, 1'b0);
    set0(1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 3'b010);
    #1;
    chk("sw_mwr", {30'd0, mem_read, mem_write}, 32'd1);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_rsp", {30'd0, p0_rsp_valid, p0_rsp_err}, 32'd2);
    chk("sw_rdata", p0_rsp_rdata, 32'd0);
    set0(1'b1, 32'h8, 32'h0, 1'b0, 3'b000);
    step();
    chk("lb_rdata", p0_rsp_rdata, 32'hFFFFFFEF);
    set0(1'b1, 32'hA, 32'h0, 1'b0, 3'b101);
    step();
    chk("lhu_rdata", p0_rsp_rdata, 32'h0000DEAD);

    // rejected requests
    for (int i = 0; i < 6; i++) begin
      set0(1'b1, err_a[i], 32'h12345678, err_we[i], err_sz[i]);
      #1;
      chk("err_rdy", {31'd0, p0_req_ready}, 32'd1);
      chk("err_mem", {30'd0, mem_read, mem_write}, 32'd0);
      step();
      chk("err_rsp", {30'd0, p0_rsp_valid, p0_rsp_err}, 32'd3);
      chk("err_rdata", p0_rsp_rdata, 32'd0);
    end

    // legal accesses at the top of memory
    set0(1'b1, 32'hFFC, 32'h0BADC0DE, 1'b1, 3'b010);
    #1;
    chk("top_mwr", {30'd0, mem_read, mem_write}, 32'd1);
    step();
    chk("top_sw_err", {31'd0, p0_rsp_err}, 32'd0);
    set0(1'b1, 32'hFFE, 32'h0, 1'b0, 3'b001);
    step();
    chk("top_lh", {p0_rsp_err, p0_rsp_rdata[30:0]}, 32'h00000BAD);

    // lock bound: one rr grant + 4 lock grants to p1, then p0, then p1
    set0(1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    step();
    set1(1'b1, 32'h20, 32'h0, 1'b0, 3'b010, 1'b1);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("lock_rdy", {30'd0, p1_req_ready, p0_req_ready}, (i == 5) ? 32'd1 : 32'd2);
      step();
      chk("lock_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, (i == 5) ? 32'd1 : 32'd2);
    end

    // lock with p0 idle must not consume the bound
    set0(1'b0, 32'h0, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("idle_lock_rdy", {31'd0, p1_req_ready}, 32'd1);
      step();
    end
    set0(1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("relock_rdy", {30'd0, p1_req_ready, p0_req_ready}, (i == 4) ? 32'd1 : 32'd2);
      step();
    end

    // reset in the same cycle as a store: no effect, no response
    set1(1'b0, 32'h0, 32'h0, 1'b0, 3'b010, 1'b0);
    set0(1'b1, 32'h40, 32'h1, 1'b1, 3'b010);
    rst = 1'b1;
    #1;
    chk("rstmid_rdy", {30'd0, p0_req_ready, mem_write}, 32'd0);
    step();
    chk("rstmid_rsp", {31'd0, p0_rsp_valid}, 32'd0);
    rst = 1'b0;
    set0(1'b1, 32'h40, 32'h0, 1'b0, 3'b010);
    step();
    chk("rstmid_lw", {p0_rsp_valid, p0_rsp_rdata[30:0]}, 32'h80000000);
    set0(1'b0, 32'h0, 32'h0, 1'b0, 3'b010);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
